sized_data_memory: RTL and testbench

- Byte-addressable data memory with RISC-V sized accesses:
  - loads: byte, half and word, signed or unsigned;
  - stores: byte, half and word.
- Uses a valid/ready request channel and a fixed-latency registered response.
- Flags out-of-range and reserved-size requests as errors.
- Sits between the core's load/store stage and the memory map; it replaces the combinational word-only memory in the data path.

---
 rtl/sized_data_memory.sv | 158 +++++++++++++++
 tb/tb_sized_data_memory.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sized_data_memory.sv
// Byte-addressable data memory with RISC-V sized loads/stores, valid/ready request, fixed-latency
// registered response. Define SIZED_MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module sized_data_memory #(
  parameter int unsigned       AWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 'h01000000,
  parameter int unsigned       MEM_BYTES = 65536,
  parameter int unsigned       LATENCY   = 1,
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned       OW      = $clog2(MEM_BYTES);
  localparam int unsigned       Words   = MEM_BYTES / 4;
  localparam logic [AWIDTH+1:0] MemEnd  = (AWIDTH+2)'(MEM_BYTES);
  localparam logic [2:0]        CntInit = 3'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [31:0] r_mem [Words];

  state_e      r_state;
  logic [2:0]  r_cnt;
  logic        r_ready;
  logic        r_valid;
  logic        r_err;
  logic [31:0] r_rdata;

  logic              w_accept;
  logic [AWIDTH:0]   w_off;
  logic [AWIDTH+1:0] w_end;
  logic [2:0]        w_nbytes;
  logic              w_misalign;
  logic              w_err;
  logic [OW-1:0]     w_idx [4];
  logic [7:0]        w_byte [4];
  logic [31:0]       w_raw;
  logic [31:0]       w_rdata;

  assign w_accept = req_valid_i & r_ready;
  // One extra bit so addresses below BASE_ADDR wrap to huge offsets and fail the range check.
  assign w_off    = {1'b0, req_addr_i} - {1'b0, BASE_ADDR};

  always_comb begin
    w_nbytes = 3'd4;
    case (req_size_i)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  assign w_end = {1'b0, w_off} + {{(AWIDTH-1){1'b0}}, w_nbytes};

`ifdef SIZED_MEM_ALIGN_CHECK_EN
  assign w_misalign = ((req_size_i == 2'b01) && w_off[0]) ||
                      ((req_size_i == 2'b10) && (w_off[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = (req_size_i == 2'b11) || (w_end > MemEnd) || w_misalign;

  // Byte-wise lane addressing lets misaligned accesses straddle two storage words.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_idx[i]  = w_off[OW-1:0] + OW'(i);
      w_byte[i] = r_mem[w_idx[i][OW-1:2]][{w_idx[i][1:0], 3'b000} +: 8];
    end
  end

  assign w_raw = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};

  always_comb begin
    w_rdata = 32'h0;
    if (!w_err && !req_we_i) begin
      case (req_size_i)
        2'b00:   w_rdata = req_unsigned_i ? {24'h0, w_raw[7:0]} : {{24{w_raw[7]}}, w_raw[7:0]};
        2'b01:   w_rdata = req_unsigned_i ? {16'h0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
        default: w_rdata = w_raw;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && req_we_i && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < w_nbytes) begin
          r_mem[w_idx[i][OW-1:2]][{w_idx[i][1:0], 3'b000} +: 8] <= req_wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 3'd0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        StIdle, StResp: begin
          if (w_accept) begin
            r_rdata <= w_rdata;
            r_err   <= w_err;
            if (LATENCY == 1) begin
              r_state <= StResp;
              r_ready <= 1'b1;
              r_valid <= 1'b1;
            end else begin
              r_state <= StWait;
              r_cnt   <= CntInit;
              r_ready <= 1'b0;
              r_valid <= 1'b0;
            end
          end else begin
            r_state <= StIdle;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        StWait: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state <= StResp;
            r_ready <= 1'b1;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign rsp_valid_o = r_valid;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_sized_data_memory.sv
// Bench: two instances (LATENCY 1 and 3) driven by directed and random requests, checked
// against a byte-array reference model.
module tb_sized_data_memory;

  localparam logic [31:0] Base = 32'h01000000;
  localparam int          MemB = 65536;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        vld [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [1:0]  size [2];
  logic        uns [2];
  logic [31:0] wd [2];

  logic        a_rdy, a_rv, a_err, b_rdy, b_rv, b_err;
  logic [31:0] a_rd, b_rd;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [2][MemB];

  sized_data_memory #(.AWIDTH(32), .BASE_ADDR(Base), .MEM_BYTES(MemB), .LATENCY(1),
                      .INIT_FILE("")) dut_a (
    .clk(clk), .rst(rst[0]), .req_valid_i(vld[0]), .req_ready_o(a_rdy), .req_we_i(we[0]),
    .req_addr_i(addr[0]), .req_size_i(size[0]), .req_unsigned_i(uns[0]),
    .req_wdata_i(wd[0]), .rsp_valid_o(a_rv), .rsp_rdata_o(a_rd), .rsp_err_o(a_err)
  );

  sized_data_memory #(.AWIDTH(32), .BASE_ADDR(Base), .MEM_BYTES(MemB), .LATENCY(3),
                      .INIT_FILE("")) dut_b (
    .clk(clk), .rst(rst[1]), .req_valid_i(vld[1]), .req_ready_o(b_rdy), .req_we_i(we[1]),
    .req_addr_i(addr[1]), .req_size_i(size[1]), .req_unsigned_i(uns[1]),
    .req_wdata_i(wd[1]), .rsp_valid_o(b_rv), .rsp_rdata_o(b_rd), .rsp_err_o(b_err)
  );

  function automatic logic rdy(input int d);
    return (d == 0) ? a_rdy : b_rdy;
  endfunction

  function automatic logic rv(input int d);
    return (d == 0) ? a_rv : b_rv;
  endfunction

  // Reference: byte array, offset arithmetic in 64-bit signed integers.
  function automatic void model_access(input int d, input logic w, input logic [31:0] a,
                                       input logic [1:0] s, input logic u,
                                       input logic [31:0] data, output logic [31:0] rd,
                                       output logic e);
    longint off = longint'(a) - longint'(Base);
    int     n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    longint v = 0;
    e  = (s == 2'd3) || (off < 0) || (off + n > MemB);
`ifdef SIZED_MEM_ALIGN_CHECK_EN
    if (!e && (off % n) != 0) e = 1'b1;
`endif
    rd = 32'h0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) mdl[d][off + i] = data[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) v = v | (longint'(mdl[d][off + i]) << (8 * i));
        if (!u && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        rd = v[31:0];
      end
    end
  endfunction

  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] data, output logic [31:0] g_rd,
                        output logic g_err, output int lat, output logic [31:0] e_rd,
                        output logic e_err);
    int t = 0;
    vld[d] = 1'b1; we[d] = w; addr[d] = a; size[d] = s; uns[d] = u; wd[d] = data;
    g_rd = 32'h0; g_err = 1'b0; lat = -1; e_rd = 32'h0; e_err = 1'b0;
    while (!rdy(d) && t < 20) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (!rdy(d)) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: ready=%0b required 1", d, rdy(d));
      vld[d] = 1'b0;
      return;
    end
    model_access(d, w, a, s, u, data, e_rd, e_err);
    @(posedge clk); #1;
    vld[d] = 1'b0;
    lat = 1;
    while (!rv(d) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    g_rd  = (d == 0) ? a_rd : b_rd;
    g_err = (d == 0) ? a_err : b_err;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; vld[d] = 1'b0; we[d] = 1'b0; addr[d] = Base; size[d] = 2'd0;
      uns[d] = 1'b0; wd[d] = 32'h0;
    end
    for (int d = 0; d < 2; d++) for (int i = 0; i < MemB; i++) mdl[d][i] = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (a_rdy !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", a_rdy); end
    if (a_rv !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", a_rv); end
    if (a_rd !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", a_rd); end
    if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", a_err); end
    if (b_rdy !== 1'b0) begin errors++; $display("FAIL reset_ready_b: got %b expected 0", b_rdy); end
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    checks++;
    if (a_rdy !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b expected 0", a_rdy); end
    @(posedge clk); #1;
    checks += 2;
    if (a_rdy !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b expected 1", a_rdy); end
    if (b_rdy !== 1'b1) begin errors++; $display("FAIL ready_after_edge_b: got %b expected 1", b_rdy); end
  endtask

  task automatic test_word_byte();
    logic [31:0] g, e; logic ge, ee; int lat;
    access(0, 1'b1, 32'h01000010, 2'd2, 1'b0, 32'hDEADBEEF, g, ge, lat, e, ee);
    checks += 3;
    if (lat != 1) begin errors++; $display("FAIL store_latency: got %0d expected 1", lat); end
    if (ge !== 1'b0) begin errors++; $display("FAIL store_err: got %b expected 0", ge); end
    if (g !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h expected 0", g); end
    access(0, 1'b0, 32'h01000010, 2'd2, 1'b0, 32'h0, g, ge, lat, e, ee);
    checks += 3;
    if (lat != 1) begin errors++; $display("FAIL load_latency: got %0d expected 1", lat); end
    if (ge !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", ge); end
    if (g !== 32'hDEADBEEF) begin errors++; $display("FAIL load_word: got %h expected deadbeef", g); end
    access(0, 1'b1, 32'h01000011, 2'd0, 1'b0, 32'h12345680, g, ge, lat, e, ee);
    access(0, 1'b0, 32'h01000011, 2'd0, 1'b0, 32'h0, g, ge, lat, e, ee);
    checks++;
    if (g !== 32'hFFFFFF80) begin errors++; $display("FAIL load_byte_signed: got %h expected ffffff80", g); end
    access(0, 1'b0, 32'h01000011, 2'd0, 1'b1, 32'h0, g, ge, lat, e, ee);
    checks++;
    if (g !== 32'h00000080) begin errors++; $display("FAIL load_byte_unsigned: got %h expected 00000080", g); end
    access(0, 1'b0, 32'h01000010, 2'd2, 1'b1, 32'h0, g, ge, lat, e, ee);
    checks++;
    if (g !== 32'hDEAD80EF) begin errors++; $display("FAIL load_word_merged: got %h expected dead80ef", g); end
  endtask

  task automatic test_errors();
    logic [31:0] g, e; logic ge, ee; int lat;
    access(0, 1'b0, Base + MemB - 2, 2'd2, 1'b0, 32'h0, g, ge, lat, e, ee);
    checks += 2;
    if (ge !== 1'b1) begin errors++; $display("FAIL range_top_err: got %b expected 1", ge); end
    if (g !== 32'h0) begin errors++; $display("FAIL range_top_rdata: got %h expected 0", g); end
    access(0, 1'b0, Base + MemB - 4, 2'd2, 1'b0, 32'h0, g, ge, lat, e, ee);
    checks++;
    if (ge !== 1'b0) begin errors++; $display("FAIL range_last_word_err: got %b expected 0", ge); end
    access(0, 1'b0, Base + MemB - 1, 2'd0, 1'b0, 32'h0, g, ge, lat, e, ee);
    checks++;
    if (ge !== 1'b0) begin errors++; $display("FAIL range_last_byte_err: got %b expected 0", ge); end
    access(0, 1'b0, 32'h00FFFFFF, 2'd0, 1'b0, 32'h0, g, ge, lat, e, ee);
    checks++;
    if (ge !== 1'b1) begin errors++; $display("FAIL below_base_err: got %b expected 1", ge); end
    access(0, 1'b1, 32'h01000010, 2'd3, 1'b0, 32'h11223344, g, ge, lat, e, ee);
    checks++;
    if (ge !== 1'b1) begin errors++; $display("FAIL size3_err: got %b expected 1", ge); end
    access(0, 1'b0, 32'h01000010, 2'd2, 1'b0, 32'h0, g, ge, lat, e, ee);
    checks++;
    if (g !== 32'hDEAD80EF) begin errors++; $display("FAIL size3_no_write: got %h expected dead80ef", g); end
  endtask

  task automatic test_misalign();
    logic [31:0] g, e; logic ge, ee; int lat;
    access(0, 1'b1, Base, 2'd2, 1'b0, 32'hA1B2C3D4, g, ge, lat, e, ee);
    access(0, 1'b0, Base + 1, 2'd1, 1'b0, 32'h0, g, ge, lat, e, ee);
    checks += 2;
`ifdef SIZED_MEM_ALIGN_CHECK_EN
    if (ge !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", ge); end
    if (g !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h expected 0", g); end
`else
    if (ge !== 1'b0) begin errors++; $display("FAIL misalign_err: got %b expected 0", ge); end
    if (g !== 32'hFFFFB2C3) begin errors++; $display("FAIL misalign_rdata: got %h expected ffffb2c3", g); end
`endif
  endtask

  task automatic test_latency3();
    logic [31:0] e; logic ee;
    vld[1] = 1'b1; we[1] = 1'b0; addr[1] = Base + 32'h40; size[1] = 2'd2; uns[1] = 1'b0;
    model_access(1, 1'b0, Base + 32'h40, 2'd2, 1'b0, 32'h0, e, ee);
    @(posedge clk); #1;
    vld[1] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks += 2;
      if (b_rdy !== (c == 3)) begin
        errors++; $display("FAIL lat3_ready cycle%0d: got %b expected %b", c, b_rdy, c == 3);
      end
      if (b_rv !== (c == 3)) begin
        errors++; $display("FAIL lat3_valid cycle%0d: got %b expected %b", c, b_rv, c == 3);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (b_rv !== 1'b0) begin errors++; $display("FAIL lat3_valid_pulse: got %b expected 0", b_rv); end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int rsp [$];
    vld[1] = 1'b1; we[1] = 1'b0; addr[1] = Base + 32'h40; size[1] = 2'd2; uns[1] = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (b_rv) rsp.push_back(c);
      if (b_rdy) acc.push_back(c);
      @(posedge clk); #1;
    end
    vld[1] = 1'b0;
    checks++;
    if (acc.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 3) begin
        errors++; $display("FAIL b2b_spacing %0d: got %0d expected 3", i, acc[i] - acc[i-1]);
      end
    end
    for (int i = 0; i < rsp.size(); i++) begin
      checks++;
      if (rsp[i] != acc[i] + 3) begin
        errors++; $display("FAIL b2b_rsp_time %0d: got %0d expected %0d", i, rsp[i], acc[i] + 3);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] g, e; logic ge, ee; int lat;
    int t = 0;
    vld[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h01000020; size[1] = 2'd2; wd[1] = 32'hCAFEF00D;
    while (!b_rdy && t < 20) begin @(posedge clk); #1; t++; end
    model_access(1, 1'b1, 32'h01000020, 2'd2, 1'b0, 32'hCAFEF00D, e, ee);
    @(posedge clk); #1;
    vld[1] = 1'b0;
    rst[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks += 2;
      if (b_rdy !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", b_rdy); end
      if (b_rv !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", b_rv); end
      @(posedge clk); #1;
    end
    rst[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (b_rv !== 1'b0) begin errors++; $display("FAIL midrst_late_valid: got %b expected 0", b_rv); end
    end
    access(1, 1'b0, 32'h01000020, 2'd2, 1'b0, 32'h0, g, ge, lat, e, ee);
    checks += 2;
    if (g !== 32'hCAFEF00D) begin errors++; $display("FAIL midrst_kept: got %h expected cafef00d", g); end
    if (lat != 3) begin errors++; $display("FAIL midrst_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_random(input int d, input int n_ops);
    logic [31:0] g, e, a; logic ge, ee; int lat, sel;
    int exp_lat = (d == 0) ? 1 : 3;
    for (int i = 0; i < 64; i += 4) access(d, 1'b1, Base + i, 2'd2, 1'b0, $urandom, g, ge, lat, e, ee);
    for (int i = 8; i > 0; i -= 4) access(d, 1'b1, Base + MemB - i, 2'd2, 1'b0, $urandom, g, ge, lat, e, ee);
    for (int k = 0; k < n_ops; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) a = Base + $urandom_range(0, 63);
      else if (sel == 7) a = Base + MemB - $urandom_range(0, 6);
      else if (sel == 8) a = Base - $urandom_range(1, 4);
      else a = $urandom;
      access(d, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, g, ge, lat, e, ee);
      checks += 3;
      if (g !== e) begin errors++; $display("FAIL rand_rdata dut%0d op%0d: got %h expected %h", d, k, g, e); end
      if (ge !== ee) begin errors++; $display("FAIL rand_err dut%0d op%0d: got %b expected %b", d, k, ge, ee); end
      if (lat != exp_lat) begin
        errors++; $display("FAIL rand_latency dut%0d op%0d: got %0d expected %0d", d, k, lat, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_byte();
    test_errors();
    test_misalign();
    test_latency3();
    test_back_to_back();
    test_reset_mid();
    test_random(0, 200);
    test_random(1, 60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
